// File: rtl/cdc_handshake_receiver_if.sv
// Bundle of the four-phase req/ack pins and the captured valid/ready stream.
// The slave modport is the receiver's view; master is the sender/consumer side.
interface cdc_handshake_receiver_if #(
  parameter int WIDTH = 8
);
  logic             req_async;
  logic [WIDTH-1:0] data_async;
  logic             ack;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output req_async,
    output data_async,
    output out_ready,
    input  ack,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  req_async,
    input  data_async,
    input  out_ready,
    output ack,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/cdc_handshake_receiver.sv
// Receive end of a four-phase req/ack crossing: synchronizes req, captures the payload
// into a valid/ready stream and returns ack only after the stream beat is accepted.
module cdc_handshake_receiver #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  cdc_handshake_receiver_if.slave bus,
  output logic [CNT_WIDTH-1:0] xfer_count,
  output logic                 busy
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_HOLD     = 2'd1;
  localparam logic [1:0] ST_WAIT_LOW = 2'd2;

  logic [1:0]             state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   req_s;

  assign req_s = sync[SYNC_STAGES-1];
  assign busy  = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      sync          <= '0;
      bus.ack       <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      xfer_count    <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.req_async};
      case (state)
        ST_IDLE: begin
          // data_async is safe to sample here: the sender holds it while req is high
          if (req_s) begin
            bus.out_data  <= bus.data_async;
            bus.out_valid <= 1'b1;
            state         <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // A premature req drop is ignored; the beat still completes normally
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.ack       <= 1'b1;
            xfer_count    <= xfer_count + 1'b1;
            state         <= ST_WAIT_LOW;
          end
        end
        ST_WAIT_LOW: begin
          if (!req_s) begin
            bus.ack <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          bus.ack       <= 1'b0;
          bus.out_valid <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
